// File: rtl/downsample_2d_if.sv
// downsample_2d_if: raster input stream and decimated output stream of downsample_2d
interface downsample_2d_if #(parameter int DATA_W = 16);
  logic              data_in_valid;
  logic              data_in_ready;
  logic [DATA_W-1:0] data_in_data;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [DATA_W-1:0] data_out_data;
  logic              data_out_last;
  modport master (
    output data_in_valid, data_in_data, data_out_ready,
    input  data_in_ready, data_out_valid, data_out_data, data_out_last
  );
  modport slave (
    input  data_in_valid, data_in_data, data_out_ready,
    output data_in_ready, data_out_valid, data_out_data, data_out_last
  );
endinterface

// File: rtl/downsample_2d.sv
// downsample_2d: keeps 1-of-fx columns and 1-of-fy rows of a raster frame
module downsample_2d #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8,
  parameter int FAC_W  = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             cont,
  input  logic [DIM_W-1:0] cfg_w_m1,
  input  logic [DIM_W-1:0] cfg_h_m1,
  input  logic [FAC_W-1:0] cfg_fx_m1,
  input  logic [FAC_W-1:0] cfg_fy_m1,
  downsample_2d_if.slave   s,
  output logic             busy,
  output logic             frame_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [DIM_W-1:0] w_m1, h_m1, x, y;
  logic [FAC_W-1:0] fx_m1, fy_m1, px, py;
  logic keep, acc, x_end, y_end, eof, last_kept;
  assign keep  = px == '0 && py == '0;
  assign acc   = s.data_in_valid && s.data_in_ready;
  assign x_end = x == w_m1;
  assign y_end = y == h_m1;
  assign eof   = acc && x_end && y_end;
  // last kept pixel: no further kept column in this row and no further kept row
  assign last_kept = (w_m1 - x) <= DIM_W'(fx_m1) && (h_m1 - y) <= DIM_W'(fy_m1);
  always_ff @(posedge CLK) state <= RESET ? IDLE : state_nx;
  always_comb state_nx = state == IDLE ? (start ? RUN : IDLE) : (eof && !cont ? IDLE : RUN);
  always_comb begin
    busy            = state == RUN;
    s.data_in_ready = busy && (!keep || !s.data_out_valid || s.data_out_ready);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {w_m1, h_m1, fx_m1, fy_m1} <= '0;
      {x, y, px, py}             <= '0;
      frame_done                 <= 1'b0;
    end else begin
      frame_done <= eof;
      if (state == IDLE && start) begin
        w_m1  <= cfg_w_m1;
        h_m1  <= cfg_h_m1;
        fx_m1 <= cfg_fx_m1;
        fy_m1 <= cfg_fy_m1;
        {x, y, px, py} <= '0;
      end else if (acc) begin
        x  <= x_end ? '0 : x + 1'b1;
        px <= (x_end || px == fx_m1) ? '0 : px + 1'b1;
        if (x_end) begin
          y  <= y_end ? '0 : y + 1'b1;
          py <= (y_end || py == fy_m1) ? '0 : py + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s.data_out_valid <= 1'b0;
      s.data_out_data  <= '0;
      s.data_out_last  <= 1'b0;
    end else if (acc && keep) begin
      s.data_out_valid <= 1'b1;
      s.data_out_data  <= s.data_in_data;
      s.data_out_last  <= last_kept;
    end else if (s.data_out_ready) begin
      s.data_out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_downsample_2d.sv
// tb_downsample_2d: directed frames against hand-computed decimated outputs
module tb_downsample_2d;
  logic clk = 1'b0, rst, start, cont, frame_done, busy;
  logic [7:0] cfg_w_m1, cfg_h_m1;
  logic [2:0] cfg_fx_m1, cfg_fy_m1;
  downsample_2d_if #(.DATA_W(16)) b ();
  downsample_2d dut (
    .CLK(clk), .RESET(rst), .start(start), .cont(cont),
    .cfg_w_m1(cfg_w_m1), .cfg_h_m1(cfg_h_m1), .cfg_fx_m1(cfg_fx_m1), .cfg_fy_m1(cfg_fy_m1),
    .s(b), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int vec = 0, bad = 0, cyc = 0, sent = 0, n_pix = 0, base = 0, stall = 0;
  int cont_off_at = 0, mid_start_at = -1, busy_low = 0, first_ov = -1;
  logic rst_req = 1'b0, st_req = 1'b0;
  logic [7:0] cw = 0, ch = 0;
  logic [2:0] cfx = 0, cfy = 0;
  int got_d[$], got_l[$], got_c[$], fd_c[$], exp_d[$], exp_l[$];
  int acc_c[64];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    rst              = rst_req;
    start            = st_req || (sent == mid_start_at);
    cont             = sent < cont_off_at;
    {cfg_w_m1, cfg_h_m1, cfg_fx_m1, cfg_fy_m1} = {cw, ch, cfx, cfy};
    b.data_in_valid  = sent < n_pix;
    b.data_in_data   = 16'(base + sent);
    b.data_out_ready = !(stall > 0 && b.data_out_valid);
    #1;
    if (b.data_out_valid && first_ov < 0) first_ov = cyc;
    if (b.data_out_valid && b.data_out_ready) begin
      got_d.push_back(int'(b.data_out_data));
      got_l.push_back(int'(b.data_out_last));
      got_c.push_back(cyc);
    end
    if (stall > 0 && b.data_out_valid) begin
      chk("hold_data", b.data_out_data, 16'(base));
      stall--;
    end
    if (frame_done) fd_c.push_back(cyc);
    if (!busy && sent < n_pix) busy_low++;
    if (b.data_in_valid && b.data_in_ready) begin
      acc_c[sent] = cyc;
      sent++;
    end
    cyc++;
  endtask
  task automatic clr;
    got_d.delete(); got_l.delete(); got_c.delete(); fd_c.delete();
    cyc = 0; sent = 0; n_pix = 0; busy_low = 0; first_ov = -1;
  endtask
  task automatic do_start(input logic [7:0] w, input logic [7:0] h, input logic [2:0] fx, input logic [2:0] fy);
    clr();
    {cw, ch, cfx, cfy} = {w, h, fx, fy};
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask
  task automatic run_frame(input int n, input int bs);
    int t;
    n_pix = n;
    base  = bs;
    t     = 0;
    while (!(sent == n_pix && !busy && !b.data_out_valid) && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) chk("timeout", 0, 1);
  endtask
  task automatic chk_outs;
    chk("n_out", got_d.size(), exp_d.size());
    foreach (exp_d[i]) if (i < got_d.size()) begin
      chk("out_data", got_d[i], exp_d[i]);
      chk("out_last", got_l[i], exp_l[i]);
    end
  endtask
  initial begin
    rst_req = 1'b1;
    tick(); tick();
    rst_req = 1'b0;
    tick();
    chk("rst_valid", b.data_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_data", b.data_out_data, 0);
    chk("rst_ready", b.data_in_ready, 0);
    // 4x4, keep every 2nd column and row
    do_start(3, 3, 1, 1);
    run_frame(16, 0);
    exp_d = '{0, 2, 8, 10}; exp_l = '{0, 0, 0, 1};
    chk_outs();
    chk("fd_count", fd_c.size(), 1);
    chk("fd_timing", fd_c.size() > 0 ? fd_c[0] : -1, acc_c[15] + 1);
    chk("idle_busy", busy, 0);
    // same frame with 3-cycle backpressure on the first output
    do_start(3, 3, 1, 1);
    stall = 3;
    run_frame(16, 0);
    chk_outs();
    chk("px1_during_stall", acc_c[1], first_ov);
    chk("px2_after_stall", acc_c[2], first_ov + 3);
    // 6x3, keep cols 0 and 3, two back-to-back continuous frames
    do_start(5, 2, 2, 0);
    cont_off_at = 20;
    run_frame(36, 0);
    cont_off_at = 0;
    exp_d = '{0, 3, 6, 9, 12, 15, 18, 21, 24, 27, 30, 33};
    exp_l = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    chk_outs();
    chk("cont_fd_count", fd_c.size(), 2);
    chk("cont_busy_low", busy_low, 0);
    // 3x2 pass-through
    do_start(2, 1, 0, 0);
    run_frame(6, 'h50);
    exp_d = '{'h50, 'h51, 'h52, 'h53, 'h54, 'h55}; exp_l = '{0, 0, 0, 0, 0, 1};
    chk_outs();
    chk("pass_rate", got_c.size() == 6 ? got_c[5] - got_c[0] : -1, 5);
    // factors larger than the frame keep only pixel (0,0)
    do_start(2, 1, 4, 3);
    run_frame(6, 'h70);
    exp_d = '{'h70}; exp_l = '{1};
    chk_outs();
    // reset mid-frame with output held valid
    do_start(3, 3, 1, 1);
    n_pix = 16; base = 'h100; stall = 100;
    for (int i = 0; i < 20 && !b.data_out_valid; i++) tick();
    tick();
    n_pix = sent;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0; stall = 0;
    tick();
    chk("mid_rst_valid", b.data_out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", b.data_out_last, 0);
    chk("mid_rst_data", b.data_out_data, 0);
    do_start(3, 3, 1, 1);
    run_frame(16, 'h200);
    exp_d = '{'h200, 'h202, 'h208, 'h20a}; exp_l = '{0, 0, 0, 1};
    chk_outs();
    // start with new config while running is ignored
    do_start(3, 3, 1, 1);
    {cw, ch, cfx, cfy} = {8'd1, 8'd1, 3'd0, 3'd0};
    mid_start_at = 5;
    run_frame(16, 0);
    mid_start_at = -1;
    exp_d = '{0, 2, 8, 10}; exp_l = '{0, 0, 0, 1};
    chk_outs();
    chk("ign_fd_count", fd_c.size(), 1);
    chk("ign_sent", sent, 16);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
